hazard_controller: RTL and testbench



---
 rtl/hazard_controller_pkg.sv | 17 +
 rtl/hazard_controller_if.sv | 25 ++
 rtl/hazard_controller_perf_counter.sv | 21 ++
 rtl/hazard_controller.sv | 127 ++++++++++++
 tb/tb_hazard_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_controller_pkg;

    localparam int HZ_BUBBLE_W = 4;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_RECOVER = 2'd1,
        HZ_DSTALL  = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard indications in, pipeline-register stall/flush controls out.
// master = hazard controller, slave = pipeline datapath.
interface hazard_controller_if;
    logic ic_miss;
    logic ld_use;
    logic ex_mispredict;
    logic dc_miss;
    logic pc_stall;
    logic i2d_stall, i2d_flush;
    logic d2e_stall, d2e_flush;
    logic e2m_stall, e2m_flush;
    logic m2w_stall, m2w_flush;

    modport master (
        input  ic_miss, ld_use, ex_mispredict, dc_miss,
        output pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
               e2m_stall, e2m_flush, m2w_stall, m2w_flush
    );

    modport slave (
        output ic_miss, ld_use, ex_mispredict, dc_miss,
        input  pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
               e2m_stall, e2m_flush, m2w_stall, m2w_flush
    );
endinterface

// File: rtl/hazard_controller_perf_counter.sv
// Saturating event counter; cleared by reset, sticks at all-ones.
module hazard_perf_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;

    // Count winning-rule cycles, holding once the counter is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_q <= count_q + W'(1);
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// state      | meaning
// RUN        | normal issue; ld_use / ic_miss handled per cycle
// RECOVER    | i2d flushed while the redirected fetch refills
// DSTALL     | d-cache miss; upstream frozen, prior state and counter held
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned RECOVERY_BUBBLES = 1
`ifdef HAZARD_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.master hz,
    output logic [1:0]          state_o
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0]   perf_dstall_cyc,
    output logic [PERF_W-1:0]   perf_lduse_bubbles,
    output logic [PERF_W-1:0]   perf_mispredicts,
    output logic [PERF_W-1:0]   perf_icmiss_cyc
`endif
);
    localparam logic [HZ_BUBBLE_W-1:0] BUBBLES = HZ_BUBBLE_W'(RECOVERY_BUBBLES);

    hazard_state_t state_q, state_d;
    hazard_state_t saved_q, saved_d;
    hazard_state_t eff_state;
    logic [HZ_BUBBLE_W-1:0] cnt_q, cnt_d;
    stage_ctl_t i2d_c, d2e_c, e2m_c, m2w_c;
    logic pc_stall;

    // Leaving DSTALL evaluates the rules as if already back in the saved state.
    assign eff_state = (state_q == HZ_DSTALL) ? saved_q : state_q;

    // State, saved state and bubble counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            saved_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fixed-priority hazard resolution: next state and stage controls.
    always_comb begin
        state_d  = eff_state;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        pc_stall = 1'b0;
        i2d_c    = '0;
        d2e_c    = '0;
        e2m_c    = '0;
        m2w_c    = '0;
        if (hz.dc_miss) begin
            pc_stall    = 1'b1;
            i2d_c.stall = 1'b1;
            d2e_c.stall = 1'b1;
            e2m_c.stall = 1'b1;
            m2w_c.flush = 1'b1;
            state_d     = HZ_DSTALL;
            saved_d     = eff_state;
        end else if (hz.ex_mispredict) begin
            i2d_c.flush = 1'b1;
            d2e_c.flush = 1'b1;
            cnt_d       = BUBBLES;
            state_d     = HZ_RECOVER;
        end else if (eff_state == HZ_RECOVER) begin
            i2d_c.flush = 1'b1;
            cnt_d       = cnt_q - HZ_BUBBLE_W'(1);
            state_d     = (cnt_q <= HZ_BUBBLE_W'(1)) ? HZ_RUN : HZ_RECOVER;
        end else if (hz.ld_use) begin
            pc_stall    = 1'b1;
            i2d_c.stall = 1'b1;
            d2e_c.flush = 1'b1;
        end else if (hz.ic_miss) begin
            pc_stall    = 1'b1;
            i2d_c.flush = 1'b1;
        end
        // Reset drains the whole pipe immediately, independent of the clock.
        if (rst) begin
            pc_stall = 1'b1;
            i2d_c    = '{stall: 1'b0, flush: 1'b1};
            d2e_c    = '{stall: 1'b0, flush: 1'b1};
            e2m_c    = '{stall: 1'b0, flush: 1'b1};
            m2w_c    = '{stall: 1'b0, flush: 1'b1};
        end
    end

    assign hz.pc_stall  = pc_stall;
    assign hz.i2d_stall = i2d_c.stall;
    assign hz.i2d_flush = i2d_c.flush;
    assign hz.d2e_stall = d2e_c.stall;
    assign hz.d2e_flush = d2e_c.flush;
    assign hz.e2m_stall = e2m_c.stall;
    assign hz.e2m_flush = e2m_c.flush;
    assign hz.m2w_stall = m2w_c.stall;
    assign hz.m2w_flush = m2w_c.flush;
    assign state_o      = state_q;

`ifdef HAZARD_PERF_EN
    logic win_dstall, win_mispredict, win_lduse, win_icmiss;

    assign win_dstall     = hz.dc_miss;
    assign win_mispredict = !hz.dc_miss && hz.ex_mispredict;
    assign win_lduse      = !hz.dc_miss && !hz.ex_mispredict &&
                            (eff_state != HZ_RECOVER) && hz.ld_use;
    assign win_icmiss     = !hz.dc_miss && !hz.ex_mispredict &&
                            (eff_state != HZ_RECOVER) && !hz.ld_use && hz.ic_miss;

    hazard_perf_counter #(.W(PERF_W)) u_perf_dstall (
        .clk(clk), .rst(rst), .inc_i(win_dstall), .count_o(perf_dstall_cyc));
    hazard_perf_counter #(.W(PERF_W)) u_perf_lduse (
        .clk(clk), .rst(rst), .inc_i(win_lduse), .count_o(perf_lduse_bubbles));
    hazard_perf_counter #(.W(PERF_W)) u_perf_mispredict (
        .clk(clk), .rst(rst), .inc_i(win_mispredict), .count_o(perf_mispredicts));
    hazard_perf_counter #(.W(PERF_W)) u_perf_icmiss (
        .clk(clk), .rst(rst), .inc_i(win_icmiss), .count_o(perf_icmiss_cyc));
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed scenarios plus random hazards
// compared against a window-based reference model.
module tb_hazard_controller;
    localparam int RB = 2;

    // {pc, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f}
    localparam logic [8:0] P_MISS  = 9'b1_10_10_10_01;
    localparam logic [8:0] P_MIS   = 9'b0_01_01_00_00;
    localparam logic [8:0] P_REC   = 9'b0_01_00_00_00;
    localparam logic [8:0] P_LDU   = 9'b1_10_01_00_00;
    localparam logic [8:0] P_IC    = 9'b1_01_00_00_00;
    localparam logic [8:0] P_RST   = 9'b1_01_01_01_01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_o;

    hazard_controller_if hz();

`ifdef HAZARD_PERF_EN
    logic [3:0] perf_dstall_cyc, perf_lduse_bubbles, perf_mispredicts, perf_icmiss_cyc;
`endif

    hazard_controller #(
        .RECOVERY_BUBBLES(RB)
`ifdef HAZARD_PERF_EN
      , .PERF_W(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz),
        .state_o(state_o)
`ifdef HAZARD_PERF_EN
      , .perf_dstall_cyc(perf_dstall_cyc),
        .perf_lduse_bubbles(perf_lduse_bubbles),
        .perf_mispredicts(perf_mispredicts),
        .perf_icmiss_cyc(perf_icmiss_cyc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bubbles left in the recovery window, and whether a
    // d-cache miss window is open (which pauses the recovery window).
    int rec_left = 0;
    bit miss_open = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl_vec();
        return {hz.pc_stall, hz.i2d_stall, hz.i2d_flush, hz.d2e_stall, hz.d2e_flush,
                hz.e2m_stall, hz.e2m_flush, hz.m2w_stall, hz.m2w_flush};
    endfunction

    task automatic step(input string tag, input bit dm, input bit mis, input bit lu, input bit ic);
        logic [8:0] exp;
        logic [1:0] exp_st;
        @(negedge clk);
        hz.dc_miss       = dm;
        hz.ex_mispredict = mis;
        hz.ld_use        = lu;
        hz.ic_miss       = ic;
        #1;
        exp_st = miss_open ? 2'd2 : (rec_left > 0 ? 2'd1 : 2'd0);
        if (dm) begin
            exp       = P_MISS;
            miss_open = 1'b1;
        end else begin
            miss_open = 1'b0;
            if (mis) begin
                exp      = P_MIS;
                rec_left = RB;
            end else if (rec_left > 0) begin
                exp = P_REC;
                rec_left--;
            end else if (lu) exp = P_LDU;
            else if (ic)     exp = P_IC;
            else             exp = '0;
        end
        check($sformatf("%s.ctl", tag), 32'(ctl_vec()), 32'(exp));
        check($sformatf("%s.state", tag), 32'(state_o), 32'(exp_st));
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check($sformatf("%s.rst_ctl", tag), 32'(ctl_vec()), 32'(P_RST));
        check($sformatf("%s.rst_state", tag), 32'(state_o), 32'd0);
        rec_left  = 0;
        miss_open = 1'b0;
        @(negedge clk);
        hz.dc_miss = 0; hz.ex_mispredict = 0; hz.ld_use = 0; hz.ic_miss = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        hz.dc_miss = 0; hz.ex_mispredict = 0; hz.ld_use = 0; hz.ic_miss = 0;
        #2;
        check("por.ctl", 32'(ctl_vec()), 32'(P_RST));
        @(negedge clk);
        rst = 1'b0;

        async_reset("reset");
        step("post_rst", 0, 0, 0, 0);

        step("lduse", 0, 0, 1, 0);
        step("lduse_next", 0, 0, 0, 0);
        step("icmiss", 0, 0, 0, 1);

        step("mis_c0", 0, 1, 0, 0);
        step("mis_c1", 0, 0, 1, 1);
        step("mis_c2", 0, 0, 1, 0);
        step("mis_c3", 0, 0, 0, 0);

        step("recmiss_c0", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("recmiss_dm%0d", i), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("recmiss_after%0d", i), 0, 0, 1, 0);

        step("dm_mis_c0", 1, 1, 0, 0);
        step("dm_mis_c1", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("dm_mis_after%0d", i), 0, 0, 0, 0);

        step("rst_rec_c0", 0, 1, 0, 0);
        async_reset("rst_rec");
        step("rst_rec_after", 0, 0, 1, 0);

        step("rst_dm_c0", 1, 0, 0, 0);
        step("rst_dm_c1", 1, 0, 0, 0);
        async_reset("rst_dm");
        step("rst_dm_after", 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) async_reset($sformatf("rnd_rst%0d", i));
            else step($sformatf("rnd%0d", i),
                      $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
                      $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25);
        end

`ifdef HAZARD_PERF_EN
        async_reset("perf");
        for (int i = 0; i < 20; i++) step($sformatf("perf_dm%0d", i), 1, 0, 0, 0);
        step("perf_idle", 0, 0, 0, 0);
        check("perf_dstall", 32'(perf_dstall_cyc), 32'd15);
        check("perf_lduse", 32'(perf_lduse_bubbles), 32'd0);
        check("perf_mis", 32'(perf_mispredicts), 32'd0);
        check("perf_ic", 32'(perf_icmiss_cyc), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
